// File: rtl/mcdt_arbiter.sv
// mcdt_arbiter: round-robin read arbiter for three MCDT slave FIFOs feeding a 2-entry output buffer.
// Define MCDT_ARB_BURST_EN to let a grantee keep the grant for up to BURST_LEN consecutive acks.
module mcdt_arbiter #(
  parameter int NUM_SLV   = 3,
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          slv0_req_i,
  input  logic          slv1_req_i,
  input  logic          slv2_req_i,
  input  logic          slv0_val_i,
  input  logic          slv1_val_i,
  input  logic          slv2_val_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic [DW-1:0] slv2_data_i,
  output logic          a2s0_ack_o,
  output logic          a2s1_ack_o,
  output logic          a2s2_ack_o,
  output logic          arb_val_o,
  output logic [DW-1:0] arb_data_o,
  output logic [1:0]    arb_id_o,
  input  logic          f2a_ready_i
);

  localparam int BCW = $clog2(BURST_LEN + 1);
`ifdef MCDT_ARB_BURST_EN
  localparam int RUN_LEN = BURST_LEN;
`else
  localparam int RUN_LEN = 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    STALL
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SLV-1:0] req, val;
  logic [DW-1:0]      data [NUM_SLV];
  logic [1:0]         last, gnt_id, cand;
  logic [1:0]         cnt, cnt_nw;
  logic [BCW-1:0]     burst_cnt;
  logic               infl, pop, push, credit, keep, found, do_ack;
  logic [2:0]         ack;
  logic [DW-1:0]      buf_data [2];
  logic [1:0]         buf_id [2];
  logic               rd_ptr, wr_ptr;

  assign req     = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign val     = {slv2_val_i, slv1_val_i, slv0_val_i};
  assign data[0] = slv0_data_i;
  assign data[1] = slv1_data_i;
  assign data[2] = slv2_data_i;

  // An ACK state means a read was acknowledged last cycle, and `last` still names that slave.
  assign infl   = (state_q == ACK);
  assign pop    = (cnt != 2'd0) && f2a_ready_i;
  assign cnt_nw = cnt - {1'b0, pop};
  assign credit = ({1'b0, cnt_nw} + {2'b00, infl}) < 3'd2;
  assign push   = infl && val[last];

  always_comb begin
    keep   = req[last] && (burst_cnt != '0) && (burst_cnt < BCW'(RUN_LEN));
    gnt_id = last;
    found  = keep;
    cand   = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((int'(last) + i) % 3);
      if (!found && req[cand]) begin
        gnt_id = cand;
        found  = 1'b1;
      end
    end
  end

  // Acks are gated by reset so they drop immediately even while requests stay high.
  always_comb begin
    state_d = IDLE;
    do_ack  = 1'b0;
    if (|req) begin
      if (credit) begin
        state_d = ACK;
        do_ack  = !rst_i;
      end else begin
        state_d = STALL;
      end
    end
  end

  assign ack        = do_ack ? (3'b001 << gnt_id) : 3'b000;
  assign a2s0_ack_o = ack[0];
  assign a2s1_ack_o = ack[1];
  assign a2s2_ack_o = ack[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last      <= 2'd2;
      burst_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (do_ack) begin
        last      <= gnt_id;
        burst_cnt <= keep ? burst_cnt + 1'b1 : BCW'(1);
      end else if (!req[last]) begin
        burst_cnt <= '0;
      end
    end
  end

  // A slave that went empty returns val low; its reserved slot is simply released.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_id[i]   <= 2'd0;
      end
    end else begin
      cnt <= cnt_nw + {1'b0, push};
      if (push) begin
        buf_data[wr_ptr] <= data[last];
        buf_id[wr_ptr]   <= last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  assign arb_val_o  = (cnt != 2'd0);
  assign arb_data_o = buf_data[rd_ptr];
  assign arb_id_o   = buf_id[rd_ptr];

endmodule

// File: tb/tb_mcdt_arbiter.sv
// tb_mcdt_arbiter: directed self-checking bench for mcdt_arbiter with a queue-based model of the slave FIFOs.
// Define MCDT_ARB_BURST_EN to select the burst-mode grant order expectations.
module tb_mcdt_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        slv0_req_i, slv1_req_i, slv2_req_i;
  logic        slv0_val_i, slv1_val_i, slv2_val_i;
  logic [31:0] slv0_data_i, slv1_data_i, slv2_data_i;
  logic        a2s0_ack_o, a2s1_ack_o, a2s2_ack_o;
  logic        arb_val_o;
  logic [31:0] arb_data_o;
  logic [1:0]  arb_id_o;
  logic        f2a_ready_i;

  logic [31:0] q0[$], q1[$], q2[$];
  logic [2:0]  req_force;
  int          ack_cyc[$], ack_id[$], out_cyc[$], out_id[$];
  logic [31:0] out_dat[$];
  int          cyc;
  int          total;
  int          bad;

  mcdt_arbiter #(
    .NUM_SLV   (3),
    .DW        (32),
    .BURST_LEN (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .slv0_req_i  (slv0_req_i),
    .slv1_req_i  (slv1_req_i),
    .slv2_req_i  (slv2_req_i),
    .slv0_val_i  (slv0_val_i),
    .slv1_val_i  (slv1_val_i),
    .slv2_val_i  (slv2_val_i),
    .slv0_data_i (slv0_data_i),
    .slv1_data_i (slv1_data_i),
    .slv2_data_i (slv2_data_i),
    .a2s0_ack_o  (a2s0_ack_o),
    .a2s1_ack_o  (a2s1_ack_o),
    .a2s2_ack_o  (a2s2_ack_o),
    .arb_val_o   (arb_val_o),
    .arb_data_o  (arb_data_o),
    .arb_id_o    (arb_id_o),
    .f2a_ready_i (f2a_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic updateReq();
    slv0_req_i = (q0.size() != 0) || req_force[0];
    slv1_req_i = (q1.size() != 0) || req_force[1];
    slv2_req_i = (q2.size() != 0) || req_force[2];
  endtask

  task automatic clearLogs();
    ack_cyc.delete();
    ack_id.delete();
    out_cyc.delete();
    out_id.delete();
    out_dat.delete();
  endtask

  // One clock: sample acks and accepted words at the falling edge, then answer acks as a FIFO would.
  task automatic applyStimulus();
    logic [2:0] ack_s;
    @(negedge clk_i);
    ack_s = {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o};
    checkOutput("ack_onehot", 64'($countones(ack_s) <= 1), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (ack_s[i]) begin
        ack_cyc.push_back(cyc);
        ack_id.push_back(i);
      end
    end
    if (arb_val_o && f2a_ready_i) begin
      out_cyc.push_back(cyc);
      out_id.push_back(int'(arb_id_o));
      out_dat.push_back(arb_data_o);
    end
    @(posedge clk_i);
    #1;
    slv0_val_i = 1'b0; slv0_data_i = 32'd0;
    slv1_val_i = 1'b0; slv1_data_i = 32'd0;
    slv2_val_i = 1'b0; slv2_data_i = 32'd0;
    if (ack_s[0] && q0.size() != 0) begin slv0_val_i = 1'b1; slv0_data_i = q0.pop_front(); end
    if (ack_s[1] && q1.size() != 0) begin slv1_val_i = 1'b1; slv1_data_i = q1.pop_front(); end
    if (ack_s[2] && q2.size() != 0) begin slv2_val_i = 1'b1; slv2_data_i = q2.pop_front(); end
    updateReq();
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int c0;
    int r;
    int eid;
    int ej;
    total = 0;
    bad   = 0;
    cyc   = 0;
    req_force = 3'b000;
    rst_i = 1'b1;
    f2a_ready_i = 1'b1;
    slv0_val_i = 1'b0; slv1_val_i = 1'b0; slv2_val_i = 1'b0;
    slv0_data_i = 32'd0; slv1_data_i = 32'd0; slv2_data_i = 32'd0;
    updateReq();

    #2;
    checkOutput("rst_val", arb_val_o, 0);
    checkOutput("rst_data", arb_data_o, 0);
    checkOutput("rst_id", arb_id_o, 0);
    checkOutput("rst_acks", {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o}, 0);
    repeat (2) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Single slave 1, five words, downstream always ready
    $display("[TB] single slave streaming");
    clearLogs();
    for (int k = 0; k < 5; k++) q1.push_back(32'hA1 + k);
    updateReq();
    c0 = cyc;
    runCycles(10);
    checkOutput("A_ack_count", ack_cyc.size(), 5);
    for (int k = 0; k < ack_cyc.size(); k++) begin
      checkOutput($sformatf("A_ack_cyc[%0d]", k), ack_cyc[k], c0 + k);
      checkOutput($sformatf("A_ack_id[%0d]", k), ack_id[k], 1);
    end
    checkOutput("A_out_count", out_cyc.size(), 5);
    for (int k = 0; k < out_cyc.size(); k++) begin
      checkOutput($sformatf("A_out_cyc[%0d]", k), out_cyc[k], c0 + 2 + k);
      checkOutput($sformatf("A_out_id[%0d]", k), out_id[k], 1);
      checkOutput($sformatf("A_out_dat[%0d]", k), out_dat[k], 32'hA1 + k);
    end

    // Backpressure: two acks fill the buffer, then stall until ready returns
    $display("[TB] backpressure stall and drain");
    clearLogs();
    f2a_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) q0.push_back(32'hD0 + k);
    updateReq();
    c0 = cyc;
    runCycles(6);
    checkOutput("D_stall_acks", ack_cyc.size(), 2);
    for (int k = 0; k < ack_cyc.size(); k++) begin
      checkOutput($sformatf("D_ack_cyc[%0d]", k), ack_cyc[k], c0 + k);
      checkOutput($sformatf("D_ack_id[%0d]", k), ack_id[k], 0);
    end
    checkOutput("D_hold_val", arb_val_o, 1);
    checkOutput("D_hold_dat", arb_data_o, 32'hD0);
    checkOutput("D_hold_id", arb_id_o, 0);
    r = cyc;
    f2a_ready_i = 1'b1;
    runCycles(6);
    checkOutput("D_total_acks", ack_cyc.size(), 4);
    if (ack_cyc.size() >= 3) checkOutput("D_resume_cyc", ack_cyc[2], r);
    checkOutput("D_out_count", out_cyc.size(), 4);
    for (int k = 0; k < out_cyc.size(); k++) begin
      checkOutput($sformatf("D_out_cyc[%0d]", k), out_cyc[k], r + k);
      checkOutput($sformatf("D_out_dat[%0d]", k), out_dat[k], 32'hD0 + k);
      checkOutput($sformatf("D_out_id[%0d]", k), out_id[k], 0);
    end

    // Slave 2 holds one word but its request drops a cycle late
    $display("[TB] late request drop");
    clearLogs();
    q2.push_back(32'hE1);
    req_force = 3'b100;
    updateReq();
    c0 = cyc;
    runCycles(2);
    req_force = 3'b000;
    updateReq();
    runCycles(4);
    checkOutput("E_ack_count", ack_cyc.size(), 2);
    for (int k = 0; k < ack_cyc.size(); k++) begin
      checkOutput($sformatf("E_ack_id[%0d]", k), ack_id[k], 2);
      checkOutput($sformatf("E_ack_cyc[%0d]", k), ack_cyc[k], c0 + k);
    end
    checkOutput("E_out_count", out_cyc.size(), 1);
    if (out_cyc.size() >= 1) begin
      checkOutput("E_out_dat", out_dat[0], 32'hE1);
      checkOutput("E_out_id", out_id[0], 2);
      checkOutput("E_out_cyc", out_cyc[0], c0 + 2);
    end
    checkOutput("E_idle_val", arb_val_o, 0);

    // Reset asserted mid-cycle with a word buffered and a request still pending
    $display("[TB] reset mid-operation");
    clearLogs();
    f2a_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) q0.push_back(32'hC0 + k);
    updateReq();
    runCycles(3);
    checkOutput("R_pre_val", arb_val_o, 1);
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("R_val", arb_val_o, 0);
    checkOutput("R_data", arb_data_o, 0);
    checkOutput("R_id", arb_id_o, 0);
    checkOutput("R_acks", {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o}, 0);
    q0.delete();
    updateReq();
    f2a_ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // All three slaves requesting straight after reset
    $display("[TB] three-way round robin");
    clearLogs();
    for (int k = 0; k < 4; k++) begin
      q0.push_back(32'h100 + k);
      q1.push_back(32'h200 + k);
      q2.push_back(32'h300 + k);
    end
    updateReq();
    c0 = cyc;
    runCycles(16);
    checkOutput("B_ack_count", ack_cyc.size(), 12);
    checkOutput("B_out_count", out_cyc.size(), 12);
    for (int k = 0; k < 12; k++) begin
`ifdef MCDT_ARB_BURST_EN
      eid = k / 4;
      ej  = k % 4;
`else
      eid = k % 3;
      ej  = k / 3;
`endif
      if (k < ack_cyc.size()) begin
        checkOutput($sformatf("B_ack_id[%0d]", k), ack_id[k], eid);
        checkOutput($sformatf("B_ack_cyc[%0d]", k), ack_cyc[k], c0 + k);
      end
      if (k < out_cyc.size()) begin
        checkOutput($sformatf("B_out_id[%0d]", k), out_id[k], eid);
        checkOutput($sformatf("B_out_dat[%0d]", k), out_dat[k], 32'h100 * (eid + 1) + ej);
        checkOutput($sformatf("B_out_cyc[%0d]", k), out_cyc[k], c0 + 2 + k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
